// File: rtl/dct_coef_seq.sv
// dct_coef_seq: sequences one 8x8 2-D DCT coefficient.
// Streams 64 pixels from an external pixel memory (1-cycle read latency),
// pairs each with a cosine weight from an external combinational LUT bank,
// and multiply-accumulates into a 48-bit signed accumulator. The result is
// scaled down by FRAC_BITS (arithmetic shift, floor rounding).
//
// Build option: define DCT_LEVEL_SHIFT_EN to subtract 128 from each pixel
// before the multiply (JPEG-style level shift). Timing does not change.
//
// Result handshake: coef/out_valid are held stable while out_valid=1 and
// out_ready=0; a transfer happens on any rising edge where both are 1, and
// the block is back in IDLE on the following cycle.
module dct_coef_seq #(
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         k1,
    input  logic [2:0]         k2,
    output logic               busy,
    output logic [5:0]         pix_addr,
    output logic               pix_re,
    input  logic [7:0]         pix_rdata,
    output logic [2:0]         lut_k1,
    output logic [2:0]         lut_k2,
    output logic [2:0]         lut_n1,
    output logic [2:0]         lut_n2,
    input  logic signed [31:0] cos_term,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] coef,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               mac_q;     // pix_rdata / cos_term valid this cycle
    logic signed [47:0] acc_q;
    logic signed [8:0]  pix_op;
    logic signed [40:0] prod;
    logic signed [47:0] acc_d;
    logic signed [31:0] coef_d;

    // Pixel operand: zero-extended pixel, optionally level-shifted to -128..127.
    always_comb begin
`ifdef DCT_LEVEL_SHIFT_EN
        pix_op = $signed({1'b0, pix_rdata}) - 9'sd128;
`else
        pix_op = $signed({1'b0, pix_rdata});
`endif
    end

    // Multiply, sign-extend, and form the next accumulator and scaled result.
    always_comb begin
        prod   = 41'(cos_term) * 41'(pix_op);
        acc_d  = acc_q + 48'(prod);
        coef_d = 32'(acc_d >>> FRAC_BITS);
    end

    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Control FSM with registered memory/LUT/result outputs and the MAC datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mac_q     <= 1'b0;
            acc_q     <= '0;
            pix_re    <= 1'b0;
            pix_addr  <= '0;
            lut_k1    <= '0;
            lut_k2    <= '0;
            lut_n1    <= '0;
            lut_n2    <= '0;
            out_valid <= 1'b0;
            coef      <= '0;
        end else begin
            // LUT pixel indices trail the address by one cycle to line up
            // with the registered memory read data.
            lut_n1 <= pix_addr[5:3];
            lut_n2 <= pix_addr[2:0];
            mac_q  <= pix_re;
            if (mac_q) begin
                acc_q <= acc_d;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lut_k1   <= k1;
                        lut_k2   <= k2;
                        acc_q    <= '0;
                        pix_addr <= '0;
                        pix_re   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (pix_addr == 6'd63) begin
                        pix_re   <= 1'b0;
                        pix_addr <= '0;
                        state_q  <= DRAIN;
                    end else begin
                        pix_addr <= pix_addr + 6'd1;
                    end
                end
                DRAIN: begin
                    // Final MAC lands this cycle; capture the scaled total.
                    coef      <= coef_d;
                    out_valid <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coef_seq.sv
// Directed bench for dct_coef_seq with a constant/indexed cosine LUT stub
// and a registered pixel-memory model.
module tb_dct_coef_seq;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [2:0]         k1;
    logic [2:0]         k2;
    logic               busy;
    logic [5:0]         pix_addr;
    logic               pix_re;
    logic [7:0]         pix_rdata;
    logic [2:0]         lut_k1;
    logic [2:0]         lut_k2;
    logic [2:0]         lut_n1;
    logic [2:0]         lut_n2;
    logic signed [31:0] cos_term;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] coef;
    logic [1:0]         dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Stub configuration
    logic               cos_mode;   // 0: constant weight, 1: weight = {n1,n2}
    logic signed [31:0] cos_const;
    logic               pix_mode;   // 0: constant pixel, 1: pixel = address
    logic [7:0]         pix_const;

`ifdef DCT_LEVEL_SHIFT_EN
    localparam logic [31:0] EXP_A   = 32'hFFFF_E040; // -8128
    localparam logic [31:0] EXP_B   = 32'd7334;
    localparam logic [31:0] EXP_C   = 32'd603;
    localparam logic [31:0] EXP_IDX = 32'hFFFF_FD5D; // -675
    localparam logic [31:0] EXP_128 = 32'd0;
`else
    localparam logic [31:0] EXP_A   = 32'd64;
    localparam logic [31:0] EXP_B   = 32'd14726;
    localparam logic [31:0] EXP_C   = 32'hFFFF_FFFB; // -5
    localparam logic [31:0] EXP_IDX = 32'd333;
    localparam logic [31:0] EXP_128 = 32'd8192;
`endif

    dct_coef_seq #(.FRAC_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k1        (k1),
        .k2        (k2),
        .busy      (busy),
        .pix_addr  (pix_addr),
        .pix_re    (pix_re),
        .pix_rdata (pix_rdata),
        .lut_k1    (lut_k1),
        .lut_k2    (lut_k2),
        .lut_n1    (lut_n1),
        .lut_n2    (lut_n2),
        .cos_term  (cos_term),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .coef      (coef),
        .dbg_state (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cosine LUT stub
    assign cos_term = cos_mode ? {26'd0, lut_n1, lut_n2} : cos_const;

    // Pixel memory: one-cycle read latency
    always @(posedge clk) begin
        if (pix_re) begin
            pix_rdata <= pix_mode ? {2'b00, pix_addr} : pix_const;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " pix_re"},    32'(pix_re),    32'd0);
        check({tag, " pix_addr"},  32'(pix_addr),  32'd0);
        check({tag, " lut_k1"},    32'(lut_k1),    32'd0);
        check({tag, " lut_k2"},    32'(lut_k2),    32'd0);
        check({tag, " lut_n1"},    32'(lut_n1),    32'd0);
        check({tag, " lut_n2"},    32'(lut_n2),    32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " coef"},      32'(coef),      32'd0);
    endtask

    // Issue start (called mid-cycle in IDLE), then check every cycle up to
    // the first DONE cycle (cycle 66). Returns mid-cycle 66.
    task automatic run_coef(input logic [2:0] a, input logic [2:0] b, input logic [31:0] exp_c);
        logic [5:0] ea;
        logic [5:0] prev_a;
        k1 = a;
        k2 = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k1 = 3'($urandom_range(0, 7));
        k2 = 3'($urandom_range(0, 7));
        prev_a = 6'd0;
        for (int c = 1; c <= 65; c++) begin
            ea = (c <= 64) ? 6'(c - 1) : 6'd0;
            check($sformatf("c%0d pix_re", c),   32'(pix_re),   (c <= 64) ? 32'd1 : 32'd0);
            check($sformatf("c%0d pix_addr", c), 32'(pix_addr), 32'(ea));
            check($sformatf("c%0d lut_n1", c),   32'(lut_n1),   32'(prev_a[5:3]));
            check($sformatf("c%0d lut_n2", c),   32'(lut_n2),   32'(prev_a[2:0]));
            check($sformatf("c%0d busy", c),     32'(busy),     32'd1);
            check($sformatf("c%0d out_valid", c), 32'(out_valid), 32'd0);
            check($sformatf("c%0d lut_k1", c),   32'(lut_k1),   32'(a));
            check($sformatf("c%0d lut_k2", c),   32'(lut_k2),   32'(b));
            prev_a = ea;
            @(posedge clk); #1;
        end
        check("c66 out_valid", 32'(out_valid), 32'd1);
        check("c66 coef",      32'(coef),      exp_c);
        check("c66 busy",      32'(busy),      32'd1);
        check("c66 pix_re",    32'(pix_re),    32'd0);
        check("c66 pix_addr",  32'(pix_addr),  32'd0);
        check("c66 lut_n1",    32'(lut_n1),    32'd0);
        check("c66 lut_n2",    32'(lut_n2),    32'd0);
        check("c66 lut_k1",    32'(lut_k1),    32'(a));
        check("c66 lut_k2",    32'(lut_k2),    32'(b));
    endtask

    // With out_ready already high, the block is idle one cycle after DONE.
    task automatic expect_idle_after(input logic [31:0] exp_c);
        @(posedge clk); #1;
        check("post busy",      32'(busy),      32'd0);
        check("post out_valid", 32'(out_valid), 32'd0);
        check("post coef hold", 32'(coef),      exp_c);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k1        = 3'd0;
        k2        = 3'd0;
        out_ready = 1'b1;
        cos_mode  = 1'b0;
        cos_const = 32'sh100;
        pix_mode  = 1'b0;
        pix_const = 8'd1;

        // Reset state before any clock edge
        #2;
        check_reset_outputs("rst");
        #1;
        rst_n = 1'b1;

        // A: weight 0x100, pixels 1, k=(6,7); start on first edge after reset
        run_coef(3'd6, 3'd7, EXP_A);
        expect_idle_after(EXP_A);

        // B: weight 0xE7, pixels 255
        cos_const = 32'sh0E7;
        pix_const = 8'd255;
        run_coef(3'd3, 3'd1, EXP_B);
        expect_idle_after(EXP_B);

        // C: negative weight, floor rounding
        cos_const = -32'sh013;
        pix_const = 8'd1;
        run_coef(3'd0, 3'd5, EXP_C);
        expect_idle_after(EXP_C);

        // D: pixels 128 (zero after level shift)
        cos_const = 32'sh100;
        pix_const = 8'd128;
        run_coef(3'd2, 3'd2, EXP_128);
        expect_idle_after(EXP_128);

        // E: weight = LUT index, pixel = address (alignment), with backpressure
        cos_mode  = 1'b1;
        pix_mode  = 1'b1;
        out_ready = 1'b0;
        run_coef(3'd4, 3'd3, EXP_IDX);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            k1 = 3'($urandom_range(0, 7));
            k2 = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            check($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d coef", i),      32'(coef),      EXP_IDX);
            check($sformatf("bp%0d busy", i),      32'(busy),      32'd1);
            check($sformatf("bp%0d pix_re", i),    32'(pix_re),    32'd0);
            check($sformatf("bp%0d lut_k1", i),    32'(lut_k1),    32'd4);
        end
        // Handshake with start held high: start must be ignored
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs busy",      32'(busy),      32'd0);
        check("hs out_valid", 32'(out_valid), 32'd0);
        check("hs pix_re",    32'(pix_re),    32'd0);
        start = 1'b0;
        @(posedge clk); #1;
        check("hs+1 busy",   32'(busy),   32'd0);
        check("hs+1 pix_re", 32'(pix_re), 32'd0);
        check("hs+1 coef",   32'(coef),   EXP_IDX);

        // F: asynchronous reset at RUN cycle 30
        cos_mode  = 1'b0;
        pix_mode  = 1'b0;
        cos_const = 32'sh100;
        pix_const = 8'd1;
        k1 = 3'd5;
        k2 = 3'd6;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 30; i++) begin
            @(posedge clk); #1;
        end
        check("mid pix_addr", 32'(pix_addr), 32'd29);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        #1;
        rst_n = 1'b1;
        run_coef(3'd6, 3'd7, EXP_A);
        expect_idle_after(EXP_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
